// File: rtl/bcd_frame_accumulator.sv
// Accumulates N two-digit BCD sums (0..18) into a 3-digit BCD total and hands it downstream.
// Optional input legality checking is enabled by defining BCD_INPUT_CHECK_EN.
module bcd_frame_accumulator #(
  parameter int N = 4
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       dav_,
  input  logic [3:0] z1,
  input  logic [3:0] z0,
  output logic       rfd,
  output logic       davD_,
  input  logic       rfdD,
  output logic [3:0] s2,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       err
);

  localparam int CW = $clog2(N + 1);

  // Handshake rules (both sides): a sender asserts its active-low valid only while the
  // receiver's ready is high, holds data stable until ready falls, then releases valid;
  // the receiver raises ready again only after seeing valid released.
  typedef enum logic [2:0] {IN_WAIT, IN_ADD, IN_REL, OUT_WAIT, OUT_ACK} state_t;

  state_t        state;
  logic [11:0]   acc;
  logic [CW-1:0] cnt;
  logic [3:0]    lz1;
  logic [3:0]    lz0;
  logic          drop;
  logic          illegal;

  function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    logic        c;
    logic [4:0]  sum;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (sum > 5'd9) begin
        r[4*i +: 4] = 4'(sum - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = sum[3:0];
        c = 1'b0;
      end
    end
    // Hundreds carry-out is dropped; it cannot occur for N <= 55 with legal inputs.
    return r;
  endfunction

`ifdef BCD_INPUT_CHECK_EN
  assign illegal = (z1 > 4'd1) || (z0 > 4'd9) || ({z1, z0} > 8'h18);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      err <= 1'b0;
    end else if (state == IN_WAIT && !dav_ && illegal) begin
      err <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IN_WAIT;
      acc   <= '0;
      cnt   <= '0;
      lz1   <= '0;
      lz0   <= '0;
      drop  <= 1'b0;
      rfd   <= 1'b1;
      davD_ <= 1'b1;
      s2    <= '0;
      s1    <= '0;
      s0    <= '0;
    end else begin
      case (state)
        IN_WAIT: begin
          if (!dav_) begin
            lz1   <= z1;
            lz0   <= z0;
            drop  <= illegal;
            rfd   <= 1'b0;
            state <= IN_ADD;
          end
        end
        IN_ADD: begin
          // A dropped sample still completes the handshake but leaves acc and cnt alone.
          if (!drop) begin
            acc <= bcd_add(acc, {4'd0, lz1, lz0});
            cnt <= cnt + 1'b1;
          end
          state <= IN_REL;
        end
        IN_REL: begin
          if (dav_) begin
            if (cnt == CW'(N)) begin
              state <= OUT_WAIT;
            end else begin
              rfd   <= 1'b1;
              state <= IN_WAIT;
            end
          end
        end
        OUT_WAIT: begin
          if (rfdD) begin
            s2    <= acc[11:8];
            s1    <= acc[7:4];
            s0    <= acc[3:0];
            davD_ <= 1'b0;
            state <= OUT_ACK;
          end
        end
        OUT_ACK: begin
          if (!rfdD) begin
            davD_ <= 1'b1;
            acc   <= '0;
            cnt   <= '0;
            rfd   <= 1'b1;
            state <= IN_WAIT;
          end
        end
        default: state <= IN_WAIT;
      endcase
    end
  end

endmodule
